// File: rtl/window_coeff_reader.sv
// window_coeff_reader
//   Walks the window-coefficient BRAM (port A, read-only) in lock-step with the
//   sample stream after each frame sync. Delays the samples to meet their
//   coefficients, then multiplies four lanes and rounds half-up.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   sync_in             frame sync; the next din is frame sample 0
//   din[63:0]           four signed 16-bit samples (lane 0 in the LSBs)
//   bram_en_a           port A enable, high in every RUN cycle
//   bram_we             port A write enable, tied low
//   bram_addr           port A word address (counter register)
//   bram_wr_data        port A write data, tied low
//   bram_rd_data[63:0]  four UQ0.16 coefficients, lane k scales din lane k
//   sync_out            sync aligned one cycle ahead of output sample 0
//   dout[63:0]          four signed 16-bit windowed samples
//   sync_err            one-cycle pulse when a resync lands mid-frame
module window_coeff_reader #(
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned BRAM_LATENCY = 3,
   parameter int unsigned MULT_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sync_in,
   input  logic [63:0]           din,
   output logic                  bram_en_a,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [63:0]           bram_wr_data,
   input  logic [63:0]           bram_rd_data,
   output logic                  sync_out,
   output logic [63:0]           dout,
   output logic                  sync_err
);

   localparam int unsigned LANES    = 4;
   localparam int unsigned LANE_W   = 16;
   localparam int unsigned PROD_W   = 33;
   localparam int unsigned SYNC_DLY = BRAM_LATENCY + MULT_LATENCY;
   localparam int unsigned RES_DLY  = MULT_LATENCY - 1;
   localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    en_q, en_d;
   logic                    sync_err_q, sync_err_d;
   logic [SYNC_DLY-1:0]     sync_dl_q, sync_dl_d;
   logic [63:0]             din_dl_q [BRAM_LATENCY];
   logic [63:0]             din_dl_d [BRAM_LATENCY];
   logic signed [PROD_W-1:0] prod_q [LANES];
   logic signed [PROD_W-1:0] prod_d [LANES];
   logic [63:0]             res_q [RES_DLY];
   logic [63:0]             res_d [RES_DLY];

   // Frame FSM and address counter; a sync always restarts the counter
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sync_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (sync_in) state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (sync_in) begin
               cnt_d      = '0;
               sync_err_d = (cnt_q != CNT_MAX);
            end
         end
         default: state_d = IDLE;
      endcase
      en_d = (state_d == RUN);
   end

   // Sample/sync delay lines and the multiply-round pipeline.
   // Samples taken outside RUN enter as zero so dout stays 0 while idle.
   always_comb begin
      sync_dl_d = {sync_dl_q[SYNC_DLY-2:0], sync_in};
      din_dl_d[0] = (state_q == RUN) ? din : 64'd0;
      for (int i = 1; i < BRAM_LATENCY; i++) din_dl_d[i] = din_dl_q[i-1];
      for (int k = 0; k < LANES; k++) begin
         prod_d[k] = $signed(din_dl_q[BRAM_LATENCY-1][k*LANE_W +: LANE_W])
                   * $signed({1'b0, bram_rd_data[k*LANE_W +: LANE_W]});
      end
      res_d[0] = 64'd0;
      for (int k = 0; k < LANES; k++) begin
         // round half-up: add 2^15 then arithmetic shift by 16
         res_d[0][k*LANE_W +: LANE_W] = LANE_W'((prod_q[k] + 33'sd32768) >>> 16);
      end
      for (int i = 1; i < RES_DLY; i++) res_d[i] = res_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         en_q       <= 1'b0;
         sync_err_q <= 1'b0;
         sync_dl_q  <= '0;
         for (int i = 0; i < BRAM_LATENCY; i++) din_dl_q[i] <= 64'd0;
         for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
         for (int i = 0; i < RES_DLY; i++) res_q[i] <= 64'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         en_q       <= en_d;
         sync_err_q <= sync_err_d;
         sync_dl_q  <= sync_dl_d;
         for (int i = 0; i < BRAM_LATENCY; i++) din_dl_q[i] <= din_dl_d[i];
         for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
         for (int i = 0; i < RES_DLY; i++) res_q[i] <= res_d[i];
      end
   end

   assign bram_en_a    = en_q;
   assign bram_we      = 1'b0;
   assign bram_addr    = cnt_q;
   assign bram_wr_data = 64'd0;
   assign sync_out     = sync_dl_q[SYNC_DLY-1];
   assign dout         = res_q[RES_DLY-1];
   assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_window_coeff_reader.sv
// Directed bench for window_coeff_reader with a 3-cycle-latency BRAM model.
module tb_window_coeff_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        sync_in;
   logic [63:0] din;
   logic        bram_en_a;
   logic        bram_we;
   logic [9:0]  bram_addr;
   logic [63:0] bram_wr_data;
   logic [63:0] bram_rd_data;
   logic        sync_out;
   logic [63:0] dout;
   logic        sync_err;

   int vectors = 0;
   int errors  = 0;

   logic [63:0] mem [1024];
   logic [63:0] r1 = 64'd0, r2 = 64'd0, r3 = 64'd0;

   localparam logic [63:0] DIN_S0  = 64'h1000_1000_1000_1000;
   localparam logic [63:0] DIN_S1  = 64'h7FFF_8000_FFFF_0001;
   localparam logic [63:0] EXP_S0  = 64'h0800_1000_0000_0400;
   localparam logic [63:0] EXP_S1  = 64'h7FFF_8001_0000_0001;

   window_coeff_reader dut (
      .clk(clk), .rst(rst), .sync_in(sync_in), .din(din),
      .bram_en_a(bram_en_a), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data),
      .sync_out(sync_out), .dout(dout), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // BRAM port A: primitive + core output registers (3 cycles)
   always @(posedge clk) begin
      if (bram_en_a) r1 <= mem[bram_addr];
      r2 <= r1;
      r3 <= r2;
   end
   assign bram_rd_data = r3;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Sync at cycle t, sample 0 at t+1, sample 1 at t+2; returns at t+7.
   task automatic sync_frame(input logic exp_err);
      sync_in = 1'b1; din = 64'd0;
      tick;                                        // t+1
      chk("addr_t1", 64'(bram_addr), 64'd0);
      chk("en_t1", 64'(bram_en_a), 64'd1);
      chk("err_t1", 64'(sync_err), 64'(exp_err));
      sync_in = 1'b0; din = DIN_S0;
      tick;                                        // t+2
      chk("err_t2", 64'(sync_err), 64'd0);
      chk("addr_t2", 64'(bram_addr), 64'd1);
      din = DIN_S1;
      tick;                                        // t+3
      din = 64'd0;
      tick;                                        // t+4
      chk("sync_out_t4", 64'(sync_out), 64'd0);
      tick;                                        // t+5
      chk("sync_out_t5", 64'(sync_out), 64'd1);
      chk("dout_t5", dout, 64'd0);
      tick;                                        // t+6
      chk("sync_out_t6", 64'(sync_out), 64'd0);
      chk("dout_s0", dout, EXP_S0);
      tick;                                        // t+7
      chk("dout_s1", dout, EXP_S1);
      chk("addr_t7", 64'(bram_addr), 64'd6);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
      mem[0] = 64'h8000_FFFF_0000_4000;
      mem[1] = 64'hFFFF_FFFF_8000_8000;
      rst = 1'b1; sync_in = 1'b0; din = 64'd0;
      tick; tick;
      chk("rst_en", 64'(bram_en_a), 64'd0);
      chk("rst_we", 64'(bram_we), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_wdata", bram_wr_data, 64'd0);
      chk("rst_sync_out", 64'(sync_out), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_err", 64'(sync_err), 64'd0);
      rst = 1'b0;

      // no sync: stays idle with full-scale input
      din = 64'h7FFF_7FFF_7FFF_7FFF;
      for (int i = 0; i < 20; i++) begin
         tick;
         chk("idle_dout", dout, 64'd0);
         chk("idle_sync_out", 64'(sync_out), 64'd0);
         chk("idle_en", 64'(bram_en_a), 64'd0);
      end

      // first sync from IDLE: no error, alignment and rounding lanes
      sync_frame(1'b0);

      // run through two frames; resync exactly at the wrap
      for (int k = 7; k < 2050; k++) begin
         chk("run_addr", 64'(bram_addr), 64'((k - 1) % 1024));
         chk("run_err", 64'(sync_err), 64'd0);
         chk("run_en", 64'(bram_en_a), 64'd1);
         sync_in = (k == 2048);
         tick;
      end
      sync_in = 1'b0;
      chk("wrap_addr", 64'(bram_addr), 64'd1);
      chk("wrap_err", 64'(sync_err), 64'd0);
      tick; tick;
      chk("wrap_sync_out_t4", 64'(sync_out), 64'd0);
      tick;
      chk("wrap_sync_out_t5", 64'(sync_out), 64'd1);

      // misaligned resync at counter 500
      for (int g = 0; g < 2000 && bram_addr != 10'd500; g++) tick;
      chk("reach_500", 64'(bram_addr), 64'd500);
      sync_frame(1'b1);

      // asynchronous reset mid-frame
      tick; tick; tick;
      rst = 1'b1;
      #1;
      chk("arst_en", 64'(bram_en_a), 64'd0);
      chk("arst_addr", 64'(bram_addr), 64'd0);
      chk("arst_dout", dout, 64'd0);
      chk("arst_sync_out", 64'(sync_out), 64'd0);
      chk("arst_err", 64'(sync_err), 64'd0);
      tick;
      rst = 1'b0;
      din = 64'h7FFF_7FFF_7FFF_7FFF;
      for (int i = 0; i < 8; i++) begin
         tick;
         chk("post_rst_en", 64'(bram_en_a), 64'd0);
         chk("post_rst_addr", 64'(bram_addr), 64'd0);
         chk("post_rst_dout", dout, 64'd0);
      end
      sync_frame(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
